// File: rtl/rv32_pkg_handshake.sv
// Shared types and helpers for the req/ack/err handshake RAM responder.
// hs_be_legal is also used by the LSU assertions.
package rv32_pkg_handshake;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } hs_state_t;

    localparam int HS_WS_W = 4;

    function automatic logic hs_be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: hs_be_legal = 1'b1;
            default:                   hs_be_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_mod_ram_1rw.sv
// Single-port word RAM with per-byte write enable and registered read.
// No reset so the array maps onto block RAM.
module rv32_mod_ram_1rw #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rv32_mod_handshake_ram.sv
// Byte-writable RAM responder on the req/ack/err handshake with wait states
// and range checking. Define RV32_HS_RAM_BE_CHECK_EN to reject illegal byte enables.
module rv32_mod_handshake_ram
    import rv32_pkg_handshake::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic        ack,
    output logic        err,
    output logic [31:0] data_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    hs_state_t            r_state, w_next;
    logic [HS_WS_W-1:0]   r_cnt;
    logic                 r_wr;
    logic [3:0]           r_be;
    logic [31:0]          r_addr, r_wdata;
    logic                 r_ack, r_err, r_rd_vld;

    logic                 w_resp, w_wr, w_range_err, w_be_err, w_err;
    logic [3:0]           w_be;
    logic [31:0]          w_addr, w_wdata, w_rdata;
    logic [32:0]          w_off;

    // With zero wait states the response edge is the latch edge, so the
    // checks and the RAM see the live inputs instead of the latched copy.
    assign w_wr    = (r_state == IDLE) ? wr     : r_wr;
    assign w_be    = (r_state == IDLE) ? be     : r_be;
    assign w_addr  = (r_state == IDLE) ? addr   : r_addr;
    assign w_wdata = (r_state == IDLE) ? data_i : r_wdata;

    assign w_off       = {1'b0, w_addr} - {1'b0, BASE_ADDR};
    assign w_range_err = w_off[32] | (w_off >= 33'(4 * DEPTH_WORDS));
`ifdef RV32_HS_RAM_BE_CHECK_EN
    assign w_be_err    = ~hs_be_legal(w_be);
`else
    assign w_be_err    = 1'b0;
`endif
    assign w_err       = w_range_err | w_be_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_resp = 1'b0;
        case (r_state)
            IDLE: if (req) begin
                if (WAIT_STATES == 0) begin
                    w_next = RESP;
                    w_resp = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    w_next = IDLE;
                end else if (r_cnt == HS_WS_W'(1)) begin
                    w_next = RESP;
                    w_resp = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            if (r_state == IDLE && req) begin
                r_cnt   <= HS_WS_W'(WAIT_STATES);
                r_wr    <= wr;
                r_be    <= be;
                r_addr  <= addr;
                r_wdata <= data_i;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - HS_WS_W'(1);
            end
            r_ack    <= w_resp & ~w_err;
            r_err    <= w_resp &  w_err;
            r_rd_vld <= w_resp & ~w_err & ~w_wr;
        end
    end

    rv32_mod_ram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_resp & ~w_err),
        .i_we    (w_wr ? w_be : 4'b0000),
        .i_addr  (w_off[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign ack    = r_ack;
    assign err    = r_err;
    // RAM output has no reset; gating keeps data_o at zero outside a read ack.
    assign data_o = r_rd_vld ? w_rdata : 32'h0;

endmodule

// File: tb/tb_rv32_mod_handshake_ram.sv
// Bench for rv32_mod_handshake_ram: three instances with different wait states,
// bases and depths, directed scenarios plus randomized traffic against a word model.
module tb_rv32_mod_handshake_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [3];
    logic        wr  [3];
    logic [3:0]  be  [3];
    logic [31:0] addr[3];
    logic [31:0] din [3];
    logic [31:0] dout[3];
    logic        ack [3];
    logic        err [3];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl   [3][1024];
    bit          known [3][1024];

    always #5 clk = ~clk;

    rv32_mod_handshake_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_d0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .be(be[0]), .addr(addr[0]),
        .data_i(din[0]), .ack(ack[0]), .err(err[0]), .data_o(dout[0]));
    rv32_mod_handshake_ram #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_d1 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .be(be[1]), .addr(addr[1]),
        .data_i(din[1]), .ack(ack[1]), .err(err[1]), .data_o(dout[1]));
    rv32_mod_handshake_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'hFFFF_F000), .WAIT_STATES(5)) u_d2 (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .be(be[2]), .addr(addr[2]),
        .data_i(din[2]), .ack(ack[2]), .err(err[2]), .data_o(dout[2]));

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : (d == 1) ? 32'h0001_0000 : 32'hFFFF_F000;
    endfunction
    function automatic int depth_of(input int d);
        return (d == 1) ? 256 : 1024;
    endfunction
    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    function automatic logic in_range(input int d, input logic [31:0] a);
        longint la, lb;
        la = longint'(a);
        lb = longint'(base_of(d));
        return (la >= lb) && (la < lb + 4 * longint'(depth_of(d)));
    endfunction

    function automatic logic be_ok(input logic [3:0] b);
`ifdef RV32_HS_RAM_BE_CHECK_EN
        return b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
`else
        return 1'b1;
`endif
    endfunction

    // Issue one transaction, hold req through the ack/err cycle, then drop it.
    task automatic do_txn(input int d, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] dat,
                          output logic o_ack, output logic o_err, output logic [31:0] o_data,
                          output int cyc, output logic o_stuck);
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; be[d] = b; addr[d] = a; din[d] = dat;
        cyc = -1; o_ack = 1'b0; o_err = 1'b0; o_data = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack[d] || err[d]) begin
                cyc = i; o_ack = ack[d]; o_err = err[d]; o_data = dout[d];
                break;
            end
        end
        @(posedge clk); #1;
        o_stuck = ack[d] | err[d];
        req[d] = 1'b0; wr[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; din[d] = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dout[d] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_state d%0d: ack=%b err=%b data_o=%h, want 0/0/0", d, ack[d], err[d], dout[d]);
            end
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic a, e, s; logic [31:0] q; int c;
        do_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0 || c !== 1 || s !== 1'b0) begin
            n_err++;
            $display("FAIL wr_basic: ack=%b err=%b cyc=%0d stuck=%b, want 1/0/1/0", a, e, c, s);
        end
        do_txn(0, 1'b0, 4'hF, 32'h10, 32'h0, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || q !== 32'hDEADBEEF || c !== 1) begin
            n_err++;
            $display("FAIL rd_basic: ack=%b data=%h cyc=%0d, want 1/deadbeef/1", a, q, c);
        end
    endtask

    task automatic test_byte_lane();
        logic a, e, s; logic [31:0] q; int c;
        do_txn(0, 1'b1, 4'hF, 32'h10, 32'h11223344, a, e, q, c, s);
        do_txn(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_err++;
            $display("FAIL lane_wr: ack=%b err=%b, want 1/0", a, e);
        end
        do_txn(0, 1'b0, 4'b0001, 32'h13, 32'h0, a, e, q, c, s);
        n_vec++;
        if (q !== 32'h1122AA44) begin
            n_err++;
            $display("FAIL lane_rd: data=%h, want 1122aa44", q);
        end
    endtask

    task automatic test_wait_states();
        logic a, e, s; logic [31:0] q; int c;
        do_txn(1, 1'b1, 4'hF, 32'h0001_0020, 32'h0BADF00D, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || c !== 4) begin
            n_err++;
            $display("FAIL ws3_wr: ack=%b cyc=%0d, want 1/4", a, c);
        end
        do_txn(1, 1'b0, 4'hF, 32'h0001_0020, 32'h0, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || c !== 4 || q !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL ws3_rd: ack=%b cyc=%0d data=%h, want 1/4/0badf00d", a, c, q);
        end
        n_vec++;
        if (s !== 1'b0) begin
            n_err++;
            $display("FAIL ws3_one_cycle: strobe still high after ack cycle=%b, want 0", s);
        end
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
            n_err++;
            $display("FAIL ws3_no_second: ack=%b err=%b, want 0/0", ack[1], err[1]);
        end
    endtask

    task automatic test_range();
        logic a, e, s; logic [31:0] q; int c;
        do_txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, a, e, q, c, s);
        n_vec++;
        if (e !== 1'b1 || a !== 1'b0 || q !== 32'h0 || c !== 1) begin
            n_err++;
            $display("FAIL range_rd: err=%b ack=%b data=%h cyc=%0d, want 1/0/0/1", e, a, q, c);
        end
        do_txn(0, 1'b1, 4'hF, 32'h0000_0FFC, 32'h5A5A5A5A, a, e, q, c, s);
        do_txn(0, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'hFFFFFFFF, a, e, q, c, s);
        n_vec++;
        if (e !== 1'b1 || a !== 1'b0) begin
            n_err++;
            $display("FAIL range_wr: err=%b ack=%b, want 1/0", e, a);
        end
        do_txn(0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0, a, e, q, c, s);
        n_vec++;
        if (q !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL range_image: data=%h, want 5a5a5a5a", q);
        end
        do_txn(1, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0, a, e, q, c, s);
        n_vec++;
        if (e !== 1'b1 || c !== 4) begin
            n_err++;
            $display("FAIL range_below: err=%b cyc=%0d, want 1/4", e, c);
        end
        do_txn(1, 1'b0, 4'hF, 32'h0001_0400, 32'h0, a, e, q, c, s);
        n_vec++;
        if (e !== 1'b1) begin
            n_err++;
            $display("FAIL range_top: err=%b, want 1", e);
        end
        do_txn(2, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'hC0FFEE00, a, e, q, c, s);
        do_txn(2, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0 || q !== 32'hC0FFEE00 || c !== 6) begin
            n_err++;
            $display("FAIL range_wrap: ack=%b err=%b data=%h cyc=%0d, want 1/0/c0ffee00/6", a, e, q, c);
        end
    endtask

    task automatic test_illegal_be();
        logic a, e, s; logic [31:0] q, exp; int c;
        do_txn(0, 1'b1, 4'hF, 32'h40, 32'h55667788, a, e, q, c, s);
        do_txn(0, 1'b1, 4'b0101, 32'h40, 32'hA1B2C3D4, a, e, q, c, s);
`ifdef RV32_HS_RAM_BE_CHECK_EN
        exp = 32'h55667788;
        n_vec++;
        if (e !== 1'b1 || a !== 1'b0) begin
            n_err++;
            $display("FAIL be0101_resp: ack=%b err=%b, want 0/1", a, e);
        end
`else
        exp = 32'h55B277D4;
        n_vec++;
        if (a !== 1'b1 || e !== 1'b0) begin
            n_err++;
            $display("FAIL be0101_resp: ack=%b err=%b, want 1/0", a, e);
        end
`endif
        do_txn(0, 1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, a, e, q, c, s);
        n_vec++;
        if (a !== be_ok(4'b0000) || e !== !be_ok(4'b0000)) begin
            n_err++;
            $display("FAIL be0000_resp: ack=%b err=%b", a, e);
        end
        do_txn(0, 1'b0, 4'hF, 32'h40, 32'h0, a, e, q, c, s);
        n_vec++;
        if (q !== exp) begin
            n_err++;
            $display("FAIL be_word: data=%h, want %h", q, exp);
        end
    endtask

    task automatic test_reset_midtxn();
        logic a, e, s; logic [31:0] q; int c; int bad;
        do_txn(2, 1'b1, 4'hF, 32'hFFFF_F080, 32'h12345678, a, e, q, c, s);
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'hFFFF_F080; din[2] = 32'hCAFEF00D;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (ack[2] !== 1'b0 || err[2] !== 1'b0 || dout[2] !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_out: ack=%b err=%b data=%h, want 0/0/0", ack[2], err[2], dout[2]);
        end
        @(negedge clk); req[2] = 1'b0; wr[2] = 1'b0;
        @(negedge clk); reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL rst_no_resp: strobes seen=%0d, want 0", bad);
        end
        do_txn(2, 1'b0, 4'hF, 32'hFFFF_F080, 32'h0, a, e, q, c, s);
        n_vec++;
        if (a !== 1'b1 || c !== 6 || q !== 32'h12345678) begin
            n_err++;
            $display("FAIL rst_read: ack=%b cyc=%0d data=%h, want 1/6/12345678", a, c, q);
        end
    endtask

    task automatic test_random(input int d);
        logic a, e, s, w, exp_err; logic [31:0] q, ad, dat, bs; logic [3:0] b; int c, idx, sel;
        bs = base_of(d);
        for (int i = 0; i < 64; i++) begin
            dat = $urandom;
            do_txn(d, 1'b1, 4'hF, bs + 32'(4 * i), dat, a, e, q, c, s);
            mdl[d][i] = dat; known[d][i] = 1'b1;
        end
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      ad = bs + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            else if (sel == 7) ad = bs - 32'(4 * $urandom_range(1, 16));
            else if (sel == 8) ad = bs + 32'(4 * depth_of(d)) + 32'($urandom_range(0, 31));
            else               ad = $urandom;
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            dat = $urandom;
            exp_err = !in_range(d, ad) || !be_ok(b);
            idx = int'((ad - bs) >> 2) % 1024;
            do_txn(d, w, b, ad, dat, a, e, q, c, s);
            n_vec++;
            if (a !== !exp_err || e !== exp_err || c !== ws_of(d) + 1 || s !== 1'b0) begin
                n_err++;
                $display("FAIL rand_resp d%0d a=%h wr=%b be=%b: ack=%b err=%b cyc=%0d stuck=%b, want ack=%b cyc=%0d",
                         d, ad, w, b, a, e, c, s, !exp_err, ws_of(d) + 1);
            end
            if (!exp_err && w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[d][idx][8*k +: 8] = dat[8*k +: 8];
            end else if (!w && (exp_err || known[d][idx])) begin
                n_vec++;
                if (q !== (exp_err ? 32'h0 : mdl[d][idx])) begin
                    n_err++;
                    $display("FAIL rand_data d%0d a=%h: data=%h, want %h", d, ad, q,
                             exp_err ? 32'h0 : mdl[d][idx]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; din[d] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_byte_lane();
        test_wait_states();
        test_range();
        test_illegal_be();
        test_random(0);
        test_random(1);
        test_reset_midtxn();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
